sprite_fetch: RTL and testbench
===============================

// Module: sprite_fetch
// PURPOSE
//  Address generator and pixel streamer in front of the packed 4-bit on-chip sprite memory.
//  - Takes one sprite request (base, width, height) and walks it row-major, one nibble address per cycle.
//  - Absorbs the memory's fixed 1-cycle read latency.
//  - Delivers palette indices with x/y tags to the frame compositor over a valid/ready stream.
// PARAMETERS
//  ADDR_W     20  nibble address width; matches the sprite memory read_addr.
//  PIX_W      4   palette index width.
//  DIM_W      10  width/height/x/y counter width.
//  BUF_DEPTH  2   output buffer entries; must be >= 2 for full throughput.
// PORTS
//  clk         in   1       system clock; all logic on its rising edge.
//  reset       in   1       asynchronous, active-high reset.
//  start       in   1       request strobe; sampled only in IDLE.
//  base_addr   in   ADDR_W  nibble address of sprite pixel (0,0).
//  width       in   DIM_W   sprite width in pixels.
//  height      in   DIM_W   sprite height in pixels.
//  flip_x      in   1       horizontal mirror request; present only with SPRITE_FETCH_MIRROR_EN.
//  busy        out  1       high from accepted start until done.
//  done        out  1       one-cycle pulse when the request completes.
//  mem_addr    out  ADDR_W  registered read address to the sprite memory.
//  mem_rd      out  1       high in a cycle whose mem_addr is a real fetch.
//  mem_data    in   PIX_W   memory data; valid exactly 1 cycle after mem_addr/mem_rd.
//  pix_valid   out  1       output pixel available.
//  pix_ready   in   1       downstream accepts a pixel when pix_valid && pix_ready.
//  pix_data    out  PIX_W   palette index.
//  pix_x       out  DIM_W   column of pix_data within the sprite.
//  pix_y       out  DIM_W   row of pix_data within the sprite.
//  pix_last    out  1       high with the final pixel of the request.
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, buffer empty, in-flight flag 0.
//  Reset mid-request aborts immediately; buffered and in-flight pixels are discarded and no done pulse is issued.
//  Request latching:
//   - IDLE -> FETCH on start: latch base, width, height and (if enabled) flip_x; busy=1 next cycle.
//   - start outside IDLE is ignored.
//   - width==0 or height==0: IDLE -> DONE. No mem_rd, no pixels; done pulses the cycle after start; busy high that one cycle.
//  FETCH state:
//   - Issue a fetch when (buf_count + inflight - pop) < BUF_DEPTH. pop = pix_valid && pix_ready this cycle.
//   - Each issued fetch sets mem_rd=1 and mem_addr=row_base+col; col then increments.
//   - At col==width-1: col=0, row_base+=width (no multiplier), row++.
//   - Address arithmetic is modulo 2^ADDR_W (wraps silently).
//   - After the fetch of (width-1, height-1): FETCH -> DRAIN.
//  Capture and buffer:
//   - The cycle after mem_rd, mem_data and its x/y/last tag are pushed into the FIFO.
//   - Push and pop in the same cycle are both honoured.
//   - The fetch credit rule guarantees the buffer never overflows.
//  Output stream:
//   - pix_* outputs are the FIFO head and hold stable while pix_valid && !pix_ready.
//   - Pixel order is row-major: x ascending within a row, rows ascending.
//  DRAIN state: no fetches. After the handshake of the pix_last pixel -> DONE.
//  DONE state: done=1 and busy=1 for one cycle, then IDLE. A start in DONE is ignored.
//  Latency: start sampled at edge k -> first mem_rd in cycle k+1 -> first pix_valid in cycle k+3.
//  Throughput: with pix_ready held high, 1 pixel/cycle sustained; total request time W*H+3 cycles to done.
// CONFIGURATION
//  SPRITE_FETCH_MIRROR_EN defined:
//   - flip_x port exists.
//   - When flip_x is latched 1, the fetch address is row_base+(width-1-col).
//   - pix_x still counts 0..width-1 in output order, so the stream is the mirrored sprite.
//  SPRITE_FETCH_MIRROR_EN undefined:
//   - No flip_x port.
//   - Address is always row_base+col; no mirror logic is synthesised.
// TESTING
//  T1 Basic walk.
//   - Stimulus: base=0x00100, 3x2, pix_ready=1, memory model returns addr[3:0].
//   - Response: mem_addr 0x100..0x105 on consecutive cycles; pixels 0,1,2,3,4,5 with (x,y) (0,0)..(2,1).
//   - pix_last only on the 6th pixel; done at cycle k+9.
//  T2 Backpressure.
//   - Stimulus: 4x4 request; pix_ready toggles 1,0,0,1 repeatedly.
//   - Response: no pixel lost or duplicated; pix_data/x/y stable while stalled; never more than BUF_DEPTH pixels outstanding.
//  T3 Zero size.
//   - Stimulus: width=0, height=5.
//   - Response: no mem_rd, no pix_valid; done one cycle after start.
//  T4 Wrap and ignored start.
//   - Stimulus: base=0xFFFFE, 4x1; pulse start again mid-request.
//   - Response: mem_addr FFFFE, FFFFF, 00000, 00001; second start ignored; exactly 4 pixels.
//  T5 Reset mid-request.
//   - Stimulus: assert reset asynchronously during FETCH of an 8x8 request.
//   - Response: all outputs 0 immediately; no done pulse.
//   - Follow-up: a new 2x2 request after reset runs cleanly from (0,0).
//  T6 Mirror (SPRITE_FETCH_MIRROR_EN).
//   - Stimulus: base=0x200, 3x1, flip_x=1.
//   - Response: mem_addr 0x202, 0x201, 0x200; pix_x 0, 1, 2.

Source files
------------

// File: rtl/sprite_fetch_if.sv
// Request, sprite-memory and pixel-stream bundle of sprite_fetch; flip_x exists only with SPRITE_FETCH_MIRROR_EN.
// master = the fetcher itself, slave = requester / sprite memory / compositor side.
interface sprite_fetch_if #(
    parameter int ADDR_W = 20,
    parameter int PIX_W  = 4,
    parameter int DIM_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [PIX_W-1:0]  mem_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic [DIM_W-1:0]  pix_x;
    logic [DIM_W-1:0]  pix_y;
    logic              pix_last;
`ifdef SPRITE_FETCH_MIRROR_EN
    logic              flip_x;

    modport master (
        input  start, base_addr, width, height, flip_x, mem_data, pix_ready,
        output busy, done, mem_addr, mem_rd, pix_valid, pix_data, pix_x, pix_y, pix_last
    );
    modport slave (
        output start, base_addr, width, height, flip_x, mem_data, pix_ready,
        input  busy, done, mem_addr, mem_rd, pix_valid, pix_data, pix_x, pix_y, pix_last
    );
`else
    modport master (
        input  start, base_addr, width, height, mem_data, pix_ready,
        output busy, done, mem_addr, mem_rd, pix_valid, pix_data, pix_x, pix_y, pix_last
    );
    modport slave (
        output start, base_addr, width, height, mem_data, pix_ready,
        input  busy, done, mem_addr, mem_rd, pix_valid, pix_data, pix_x, pix_y, pix_last
    );
`endif
endinterface

// File: rtl/sprite_fetch.sv
// Row-major sprite walker: start -> first mem_rd +1 cycle -> first pix_valid +3 cycles, 1 pixel/cycle when unstalled.
// Fetches are credit-gated against buffer space so pix_ready backpressure never overflows; mirror via SPRITE_FETCH_MIRROR_EN.
module sprite_fetch #(
    parameter int ADDR_W    = 20,
    parameter int PIX_W     = 4,
    parameter int DIM_W     = 10,
    parameter int BUF_DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sprite_fetch_if.master bus
);
    // A fetch is outstanding for two cycles (address register, then RAM output) before it lands,
    // so storage holds BUF_DEPTH+1 entries and the credit counts both stages.
    localparam int FIFO_D = BUF_DEPTH + 1;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int OUT_W  = CNT_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic [PIX_W-1:0] dat;
        logic [DIM_W-1:0] x;
        logic [DIM_W-1:0] y;
        logic             last;
    } pix_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;

    logic [DIM_W-1:0]  rd_x_q, rd_y_q;
    logic              rd_last_q;
    logic              dat_vld_q;
    logic [DIM_W-1:0]  dat_x_q, dat_y_q;
    logic              dat_last_q;

    pix_t              fifo_q [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DIM_W-1:0]  col_off;
    logic [OUT_W-1:0]  outstanding;
    logic              credit, last_col, last_row, push, pop, pix_vld;
    pix_t              head;

`ifdef SPRITE_FETCH_MIRROR_EN
    logic flip_q, flip_d;
    assign col_off = flip_q ? (width_q - DIM_W'(1) - col_q) : col_q;
`else
    assign col_off = col_q;
`endif

    assign head        = fifo_q[rd_ptr_q];
    assign pix_vld     = (cnt_q != '0);
    assign pop         = pix_vld && bus.pix_ready;
    assign push        = dat_vld_q;
    assign last_col    = (col_q == width_q - DIM_W'(1));
    assign last_row    = (row_q == height_q - DIM_W'(1));
    assign outstanding = OUT_W'(cnt_q) + OUT_W'(mem_rd_q) + OUT_W'(dat_vld_q) - OUT_W'(pop);
    assign credit      = (outstanding < OUT_W'(FIFO_D));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        width_d    = width_q;
        height_d   = height_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
`ifdef SPRITE_FETCH_MIRROR_EN
        flip_d     = flip_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    row_base_d = bus.base_addr;
                    width_d    = bus.width;
                    height_d   = bus.height;
                    col_d      = '0;
                    row_d      = '0;
`ifdef SPRITE_FETCH_MIRROR_EN
                    flip_d     = bus.flip_x;
`endif
                    state_d    = (bus.width == '0 || bus.height == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (credit) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = row_base_q + ADDR_W'(col_off);
                    if (last_col) begin
                        // Row stride accumulates by addition, so no multiplier is needed.
                        col_d      = '0;
                        row_base_d = row_base_q + ADDR_W'(width_q);
                        row_d      = row_q + DIM_W'(1);
                        if (last_row) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head.last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            row_base_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_last_q  <= 1'b0;
            dat_vld_q  <= 1'b0;
            dat_x_q    <= '0;
            dat_y_q    <= '0;
            dat_last_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
`ifdef SPRITE_FETCH_MIRROR_EN
            flip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
            width_q    <= width_d;
            height_q   <= height_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
`ifdef SPRITE_FETCH_MIRROR_EN
            flip_q     <= flip_d;
`endif
            if (mem_rd_d) begin
                rd_x_q    <= col_q;
                rd_y_q    <= row_q;
                rd_last_q <= last_col && last_row;
            end
            // Tags follow the fetch through the RAM stage so they meet mem_data.
            dat_vld_q  <= mem_rd_q;
            dat_x_q    <= rd_x_q;
            dat_y_q    <= rd_y_q;
            dat_last_q <= rd_last_q;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{dat: bus.mem_data, x: dat_x_q, y: dat_y_q, last: dat_last_q};
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.pix_valid = pix_vld;
    assign bus.pix_data  = pix_vld ? head.dat  : '0;
    assign bus.pix_x     = pix_vld ? head.x    : '0;
    assign bus.pix_y     = pix_vld ? head.y    : '0;
    assign bus.pix_last  = pix_vld ? head.last : 1'b0;
endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch: address and pixel scoreboards fed at request time, checked as the DUT emits.
module tb_sprite_fetch;
    localparam int ADDR_W    = 20;
    localparam int PIX_W     = 4;
    localparam int DIM_W     = 10;
    localparam int BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    bit   held_vld = 1'b0;
    logic [31:0] held_val;
    logic [31:0] cur_pix;
    logic [31:0] aq [$];
    logic [31:0] pq [$];
    int   k;

    sprite_fetch_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DIM_W(DIM_W)) bus ();

    sprite_fetch #(
        .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DIM_W(DIM_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Sprite memory model: one-cycle read latency, returns the low address nibble.
    always @(posedge clk) bus.mem_data <= bus.mem_addr[3:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix_pack(input logic [3:0] d, input logic [9:0] x,
                                             input logic [9:0] y, input logic l);
        return {7'd0, d, x, y, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            cur_pix = pix_pack(bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last);
            if (bus.mem_rd) begin
                check("rd_expected", 32'(aq.size() != 0), 32'd1);
                if (aq.size() != 0) check("mem_addr", 32'(bus.mem_addr), aq.pop_front());
            end
            if (bus.pix_valid) check("pix_expected", 32'(pq.size() != 0), 32'd1);
            if (held_vld) begin
                check("stall_valid", 32'(bus.pix_valid), 32'd1);
                check("stall_hold", cur_pix, held_val);
            end
            if (bus.pix_valid && bus.pix_ready && pq.size() != 0)
                check("pix", cur_pix, pq.pop_front());
            held_vld = bus.pix_valid && !bus.pix_ready;
            held_val = cur_pix;
        end else begin
            held_vld = 1'b0;
        end
    end

    task automatic do_start(input logic [19:0] base, input int w, input int h, input bit flip,
                            output int kk);
        logic [19:0] a;
        bus.base_addr = base;
        bus.width     = DIM_W'(w);
        bus.height    = DIM_W'(h);
`ifdef SPRITE_FETCH_MIRROR_EN
        bus.flip_x    = flip;
`endif
        bus.start     = 1'b1;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                a = base + 20'(y * w) + 20'(flip ? (w - 1 - x) : x);
                aq.push_back(32'(a));
                pq.push_back(pix_pack(a[3:0], DIM_W'(x), DIM_W'(y), (x == w - 1) && (y == h - 1)));
            end
        end
        tick();
        bus.start = 1'b0;
        kk = cyc;
    endtask

    task automatic run_req(input string tag, input int kk, input int exp_lat,
                           input logic [3:0] pat, input int restart_at);
        bit got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            bus.pix_ready = pat[cyc % 4];
            bus.start     = (cyc - kk == restart_at);
            tick();
            if (bus.done) got = 1'b1;
        end
        bus.start     = 1'b0;
        bus.pix_ready = 1'b1;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(cyc - kk), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        check({tag, "_addr_left"}, 32'(aq.size()), 32'd0);
        check({tag, "_pix_left"}, 32'(pq.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {28'd0, bus.busy, bus.done, bus.mem_rd, bus.pix_valid}, 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_pix"}, pix_pack(bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.width     = '0;
        bus.height    = '0;
        bus.pix_ready = 1'b1;
`ifdef SPRITE_FETCH_MIRROR_EN
        bus.flip_x    = 1'b0;
`endif
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // T1 basic 3x2 walk
        do_start(20'h00100, 3, 2, 1'b0, k);
        check("t1_busy", 32'(bus.busy), 32'd1);
        run_req("t1", k, 9, 4'b1111, -1);

        // T2 backpressure 1,0,0,1
        do_start(20'h002A0, 4, 4, 1'b0, k);
        run_req("t2", k, -1, 4'b1001, -1);

        // T3 zero width
        do_start(20'h00500, 0, 5, 1'b0, k);
        check("t3_done", {30'd0, bus.done, bus.busy}, 32'd3);
        tick();
        check("t3_after", {30'd0, bus.done, bus.busy}, 32'd0);
        repeat (4) tick();
        check("t3_no_pix", 32'(pq.size()), 32'd0);

        // T4 address wrap and a start pulse mid-request
        do_start(20'hFFFFE, 4, 1, 1'b0, k);
        run_req("t4", k, 7, 4'b1111, 2);

        // T5 asynchronous reset during an 8x8 fetch
        do_start(20'h01000, 8, 8, 1'b0, k);
        repeat (5) tick();
        mon_en = 1'b0;
        #3 rst = 1'b1;
        #1 check_all_zero("t5_reset");
        aq.delete();
        pq.delete();
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", {30'd0, bus.done, bus.busy}, 32'd0);
        end
        mon_en = 1'b1;
        do_start(20'h00040, 2, 2, 1'b0, k);
        run_req("t5_follow", k, 7, 4'b1111, -1);

`ifdef SPRITE_FETCH_MIRROR_EN
        // T6 horizontal mirror
        do_start(20'h00200, 3, 1, 1'b1, k);
        run_req("t6", k, 6, 4'b1111, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
